mips_cpu_muldiv_ctrl: RTL and testbench
=======================================

Name: mips_cpu_muldiv_ctrl

Overview:
Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU resource and the architectural HI/LO registers. It is shared with MTHI/MTLO writes and MFHI/MFLO reads. It sits beside the ALU: the CPU control unit issues an op with the ALU operands A/B, stalls on busy, and reads hi/lo. A radix-2 iterative engine (shift-add multiply, restoring divide on magnitudes) runs 32 steps under a small FSM.

Parameters:
ITERS, 32, number of iteration steps; fixed to the operand width, not for override.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  issue request; sampled only in IDLE
op  in  2  0=MULT 1=MULTU 2=DIV 3=DIVU
a  in  32  rs operand (multiplicand/dividend)
b  in  32  rt operand (multiplier/divisor)
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  32  MTHI/MTLO data
busy  out  1  registered; high when state != IDLE
done  out  1  one-cycle pulse when HI/LO are updated by an op
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and work registers cleared. Reset mid-operation aborts the op and leaves HI/LO=0.
- FSM states: IDLE, ITER, FIX.
  - IDLE -> ITER on start.
  - ITER -> FIX after ITERS steps.
  - FIX -> IDLE unconditionally.
- Edge E0 (start high in IDLE):
  - Latch op and sign flags.
  - Signed ops latch |a| and |b|; unsigned ops latch a and b as-is.
  - Counter loads 31; busy=1 from the next cycle.
- ITER, edges E1..E32: one step per edge; counter decrements; leave on the edge where the counter is 0.
- FIX, edge E33:
  - Apply sign correction. Product is negated if sign(a)^sign(b). Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a.
  - Write HI/LO; state returns to IDLE.
  - done=1 for the one cycle after E33; busy=0 in that same cycle.
- Latency: hi/lo valid and done high 33 cycles after the start edge. Back-to-back start is accepted in the done cycle.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Truncation is toward zero.
- Divide by zero (b==0, signed or unsigned): lo=32'hFFFF_FFFF, hi=a. Same latency; no exception.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- start while busy: ignored; the in-flight op is unaffected. The CPU must stall on busy.
- mthi/mtlo in IDLE without start: HI/LO take wdata at that edge. mthi and mtlo may both be high; both registers are written.
- mthi/mtlo while busy: dropped.
- start and mthi/mtlo in the same IDLE cycle: start wins; the writes are dropped.
- hi/lo outputs keep their old values throughout ITER/FIX. They change only at the FIX edge, on MTHI/MTLO, or on reset.
- op values outside the enum cannot occur (2-bit field is fully decoded).

Optional Feature:
Macro: MIPS_CPU_MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU form the full 64-bit product in a single ITER cycle, so the counter is not used for multiplies. Multiply latency is 2 cycles: E1 computes, E2 is FIX; done follows E2. Divide behaviour is unchanged (33 cycles).
- Undefined: multiply is iterative and takes 33 cycles, as above.
- Result values are identical either way.

Decomposition:
- Package mips_cpu_muldiv_pkg:
  - muldiv_op_t enum: MULT, MULTU, DIV, DIVU.
  - muldiv_state_t enum: IDLE, ITER, FIX.
  - Constant MULDIV_ITERS = 32.
- Sub-module mips_cpu_divstep: combinational single restoring-divide step. Inputs: partial remainder, quotient/dividend shift register, divisor. Outputs: the next values of both.
- Multiply step and sign correction stay inline in the controller.

Test Plan:
- MULTU a=32'hFFFF_FFFF b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; done exactly 33 cycles after the start edge; busy high for 33 cycles.
- MULT a=-3 b=5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1. DIV a=-7 b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU a=7 b=0 -> lo=32'hFFFF_FFFF, hi=7. DIV a=32'h8000_0000 b=32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- Busy-time checks:
  - start issued during DIVU 100/7 with different operands -> ignored; result lo=14, hi=2.
  - mthi wdata=5 during busy -> dropped.
  - mthi wdata=5 in IDLE -> hi=5 next cycle.
- Reset asserted on cycle 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0. A later start with a=6 b=7 gives lo=42.
- With MIPS_CPU_MULDIV_FAST_MULT_EN: MULTU 6*7 -> lo=42, hi=0, done 2 cycles after start. DIVU latency is still 33 cycles.

Source files
------------

// File: rtl/mips_cpu_muldiv_pkg.sv
// rtl/mips_cpu_muldiv_pkg.sv - shared types and constants for the mult/div sequencer
package mips_cpu_muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/mips_cpu_divstep.sv
// rtl/mips_cpu_divstep.sv - one combinational restoring-divide step on magnitudes
module mips_cpu_divstep (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Dividend bits shift out of the top of quo_i into the remainder; quotient bits enter at the bottom.
  assign shifted = {rem_i, quo_i[31]};
  assign diff    = shifted - {1'b0, div_i};

  always_comb begin
    rem_o = shifted[31:0];
    quo_o = {quo_i[30:0], 1'b0};
    if (!diff[32]) begin
      rem_o = diff[31:0];
      quo_o = {quo_i[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// rtl/mips_cpu_muldiv_ctrl.sv - MULT/DIV sequencer with HI/LO registers
// MIPS_CPU_MULDIV_FAST_MULT_EN: single-cycle 64-bit multiply instead of 32 shift-add steps.
module mips_cpu_muldiv_ctrl
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state_q;
  muldiv_op_t    op_q;
  logic [4:0]    cnt_q;
  logic          neg_q, nega_q, dz_q;
  logic [31:0]   acc_q, sh_q, opd_q;
  logic [31:0]   hi_q, lo_q;
  logic          busy_q, done_q;

  muldiv_op_t  op_in;
  logic        signed_in, mul_in, is_mul_q, last_step;
  logic [31:0] abs_a, abs_b;
  logic [31:0] drem_d, dquo_d;
  logic [63:0] prod_fix_d;
  logic [31:0] quo_fix_d, rem_fix_d;

  assign op_in     = muldiv_op_t'(op);
  assign signed_in = (op_in == MULT) || (op_in == DIV);
  assign mul_in    = (op_in == MULT) || (op_in == MULTU);
  assign abs_a     = (signed_in && a[31]) ? -a : a;
  assign abs_b     = (signed_in && b[31]) ? -b : b;
  assign is_mul_q  = (op_q == MULT) || (op_q == MULTU);

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod_d;
  assign fast_prod_d = 64'(opd_q) * 64'(sh_q);
  assign last_step   = is_mul_q || (cnt_q == 5'd0);
`else
  logic [32:0] msum_d;
  assign msum_d    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : 33'd0);
  assign last_step = (cnt_q == 5'd0);
`endif

  mips_cpu_divstep u_divstep (
    .rem_i (acc_q),
    .quo_i (sh_q),
    .div_i (opd_q),
    .rem_o (drem_d),
    .quo_o (dquo_d)
  );

  // Divide-by-zero leaves the remainder as |a| so sign correction restores a; only the quotient is forced.
  assign prod_fix_d = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
  assign quo_fix_d  = dz_q ? 32'hFFFF_FFFF : (neg_q ? -sh_q : sh_q);
  assign rem_fix_d  = nega_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MULT;
      cnt_q   <= 5'd0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= 32'd0;
      sh_q    <= 32'd0;
      opd_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op_in;
            neg_q   <= signed_in && (a[31] ^ b[31]);
            nega_q  <= signed_in && a[31];
            dz_q    <= (b == 32'd0);
            acc_q   <= 32'd0;
            sh_q    <= mul_in ? abs_b : abs_a;
            opd_q   <= mul_in ? abs_a : abs_b;
            cnt_q   <= 5'(MULDIV_ITERS - 1);
            state_q <= ITER;
            busy_q  <= 1'b1;
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        ITER: begin
          if (is_mul_q) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
            {acc_q, sh_q} <= fast_prod_d;
`else
            acc_q <= msum_d[32:1];
            sh_q  <= {msum_d[0], sh_q[31:1]};
`endif
          end else begin
            acc_q <= drem_d;
            sh_q  <= dquo_d;
          end
          cnt_q <= cnt_q - 5'd1;
          if (last_step) state_q <= FIX;
        end
        FIX: begin
          if (is_mul_q) begin
            {hi_q, lo_q} <= prod_fix_d;
          end else begin
            hi_q <= rem_fix_d;
            lo_q <= quo_fix_d;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// tb/tb_mips_cpu_muldiv_ctrl.sv - self-checking bench for mips_cpu_muldiv_ctrl
module tb_mips_cpu_muldiv_ctrl;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  mips_cpu_muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic; SV signed division truncates toward zero.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ehi, output logic [31:0] elo);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULT:  begin q = sx * sy; p = q; ehi = p[63:32]; elo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; ehi = p[63:32]; elo = p[31:0]; end
      OP_DIV: begin
        if (y == 0) begin ehi = x; elo = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx % sy; p = q; elo = p[31:0]; p = r; ehi = p[31:0]; end
      end
      default: begin
        if (y == 0) begin ehi = x; elo = 32'hFFFF_FFFF; end
        else begin ehi = x % y; elo = x / y; end
      end
    endcase
  endtask

  function automatic int exp_lat(input logic [1:0] o);
    return (o == OP_MULT || o == OP_MULTU) ? MUL_LAT : 33;
  endfunction

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
  endtask

  // Issues one op and returns edges from the start edge to the done sample, plus busy-high samples.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bc);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0; bc = 0;
    forever begin
      if (busy) bc++;
      if (done || lat >= 100) break;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc, k;
    logic [31:0] ehi, elo, hold_hi, hold_lo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};

    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = OP_MULT; a = 32'd0; b = 32'd0; wdata = 32'd0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op)));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(exp_lat(vecs[i].op)));
      check($sformatf("vec%0d_busy_in_done", i), 64'(busy), 64'd0);
      tick();
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // start and mthi while a divide is in flight must both be ignored
    op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    hold_hi = hi; hold_lo = lo;
    op = OP_MULTU; a = 32'd123; b = 32'd456; start = 1'b1; mthi = 1'b1; wdata = 32'd5;
    tick();
    start = 1'b0; mthi = 1'b0;
    check("busy_mthi_dropped", 64'(hi), 64'(hold_hi));
    check("busy_lo_held", 64'(lo), 64'(hold_lo));
    wait_done(k);
    check("busy_start_lat", 64'(6 + k), 64'd33);
    check("busy_start_lo", 64'(lo), 64'd14);
    check("busy_start_hi", 64'(hi), 64'd2);

    // reset in the middle of a multiply
    op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'h1234_5678; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    run_op(OP_MULTU, 32'd6, 32'd7, lat, bc);
    check("after_rst_lo", 64'(lo), 64'd42);
    check("after_rst_hi", 64'(hi), 64'd0);
    check("after_rst_lat", 64'(lat), 64'(MUL_LAT));
    tick();

    mthi = 1'b1; wdata = 32'd5;
    tick();
    mthi = 1'b0;
    check("mthi_idle_hi", 64'(hi), 64'd5);
    check("mthi_idle_lo", 64'(lo), 64'd42);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mthilo_lo", 64'(lo), 64'hA5A5_A5A5);

    // start beats a simultaneous MTHI/MTLO
    op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
    tick();
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("start_wins_hi", 64'(hi), 64'hA5A5_A5A5);
    check("start_wins_lo", 64'(lo), 64'hA5A5_A5A5);
    wait_done(k);
    check("start_wins_res_lo", 64'(lo), 64'd6);
    check("start_wins_res_hi", 64'(hi), 64'd0);

    // random back-to-back ops, each new start lands in the previous done cycle
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      model(ro, ra, rb, ehi, elo);
      run_op(ro, ra, rb, lat, bc);
      check($sformatf("rnd%0d_hi", i), 64'(hi), 64'(ehi));
      check($sformatf("rnd%0d_lo", i), 64'(lo), 64'(elo));
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(ro)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
